pipe_multiplier_top: RTL and testbench

- Multi-cycle, iterative 64x64 -> 128-bit unsigned multiplier.
- Used as the product engine of the Barrett reduction datapath; two instances are chained there, with finish_o of one driving start_i of the next.
- Computes the product from NUM_MULS 32x32 partial products, accumulating one per cycle.
- Fixed latency is NUM_MULS+2 cycles, so consumers can align side data with a delay line.

---
 rtl/multiplier_pkg.sv | 37 +++
 rtl/pipe_multiplier_if.sv | 26 ++
 rtl/pipe_multiplier_top_delay_line.sv | 22 ++
 rtl/pipe_multiplier_top.sv | 113 +++++++++++
 tb/tb_pipe_multiplier_top.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared widths, latency and state encoding for the iterative 64x64 multiplier.
// Consumers size their alignment delay lines from MULT_LATENCY.
package multiplier_pkg;

  localparam int DATA_W       = 64;
  localparam int LIMB_W       = 32;
  localparam int NUM_MULS     = (DATA_W / LIMB_W) * (DATA_W / LIMB_W);
  localparam int MULT_LATENCY = NUM_MULS + 2;
  localparam int CNT_W        = $clog2(NUM_MULS);
  localparam int PROD_W       = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Step k: bit 1 selects the high limb of a, bit 0 the high limb of b,
  // so the order is lo*lo, lo*hi, hi*lo, hi*hi with shifts 0, 32, 32, 64.
  function automatic logic [PROD_W-1:0] partial_product(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [CNT_W-1:0]  k
  );
    logic [LIMB_W-1:0]   limb_a;
    logic [LIMB_W-1:0]   limb_b;
    logic [2*LIMB_W-1:0] prod;
    logic [PROD_W-1:0]   wide;
    limb_a = k[1] ? a[DATA_W-1:LIMB_W] : a[LIMB_W-1:0];
    limb_b = k[0] ? b[DATA_W-1:LIMB_W] : b[LIMB_W-1:0];
    prod   = limb_a * limb_b;
    wide   = {{(PROD_W - 2*LIMB_W){1'b0}}, prod};
    return wide << (LIMB_W * (int'(k[1]) + int'(k[0])));
  endfunction

endpackage

// File: rtl/pipe_multiplier_if.sv
// Request/result bundle of the iterative multiplier plus a state debug tap.
interface pipe_multiplier_if;
  import multiplier_pkg::*;

  // Handshake: start_i is taken only while busy_o is low (FSM idle); the
  // operands are captured on that same edge. finish_o pulses for one cycle
  // when outdata_r_o holds the new product; there is no backpressure.
  logic              start_i;
  logic              busy_o;
  logic              finish_o;
  logic [DATA_W-1:0] indata_a_i;
  logic [DATA_W-1:0] indata_b_i;
  logic [PROD_W-1:0] outdata_r_o;
  mult_state_t       dbg_state;

  modport slave (
    input  start_i, indata_a_i, indata_b_i,
    output busy_o, finish_o, outdata_r_o, dbg_state
  );

  modport master (
    output start_i, indata_a_i, indata_b_i,
    input  busy_o, finish_o, outdata_r_o, dbg_state
  );

endinterface

// File: rtl/pipe_multiplier_top_delay_line.sv
// Plain register chain (no reset) used to align side data with the multiplier.
module delay_line #(
  parameter int SHIFT = 1,
  parameter int DATA  = 1
) (
  input  logic            clk_i,
  input  logic [DATA-1:0] data_i,
  output logic [DATA-1:0] data_o
);

  logic [DATA-1:0] stage [SHIFT];

  always_ff @(posedge clk_i) begin
    stage[0] <= data_i;
    for (int i = 1; i < SHIFT; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign data_o = stage[SHIFT-1];

endmodule

// File: rtl/pipe_multiplier_top.sv
// Iterative 64x64->128 unsigned multiplier: one 32x32 partial product per cycle.
// Optional MULT_TRACE_EN adds a per-cycle trace and a finish-timing self-check.
module pipe_multiplier_top
  import multiplier_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_multiplier_if.slave  bus
);

  mult_state_t       state, state_n;
  logic              busy, busy_n;
  logic              finish, finish_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] op_a, op_a_n;
  logic [DATA_W-1:0] op_b, op_b_n;
  logic [PROD_W-1:0] acc, acc_n;
  logic [PROD_W-1:0] result, result_n;
  logic              accept;

  assign accept = (state == IDLE) && bus.start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy   <= 1'b0;
      finish <= 1'b0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      busy   <= busy_n;
      finish <= finish_n;
      cnt    <= cnt_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      acc    <= acc_n;
      result <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    busy_n   = busy;
    finish_n = 1'b0;
    cnt_n    = cnt;
    op_a_n   = op_a;
    op_b_n   = op_b;
    acc_n    = acc;
    result_n = result;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_a_n  = bus.indata_a_i;
          op_b_n  = bus.indata_b_i;
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = MUL;
        end
      end
      MUL: begin
        acc_n = acc + partial_product(op_a, op_b, cnt);
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(NUM_MULS - 1)) begin
          state_n = SUM;
        end
      end
      SUM: begin
        result_n = acc;
        state_n  = DONE;
      end
      DONE: begin
        // Leaving DONE lands in IDLE, so a start held during the pulse is taken.
        finish_n = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy_o      = busy;
  assign bus.finish_o    = finish;
  assign bus.outdata_r_o = result;
  assign bus.dbg_state   = state;

`ifdef MULT_TRACE_EN
  logic accept_dly;

  delay_line #(
    .SHIFT (MULT_LATENCY),
    .DATA  (1)
  ) u_finish_check (
    .clk_i  (clk_i),
    .data_i (accept && !rst_i),
    .data_o (accept_dly)
  );

  always_ff @(posedge clk_i) begin
    $display("[%0t] state=%s busy=%0b finish=%0b cnt=%0d acc=%h",
             $time, state.name(), busy, finish, cnt, acc);
    if (!rst_i && state == DONE && !accept_dly) begin
      $display("[%0t] trace: finish pulse not aligned with start", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_pipe_multiplier_top.sv
// Directed-vector bench for pipe_multiplier_top: timing, arithmetic corners,
// start-while-busy, back-to-back starts and mid-operation reset.
module tb_pipe_multiplier_top;
  import multiplier_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errs;
  logic seen_finish;

  pipe_multiplier_if mif ();

  pipe_multiplier_top dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PROD_W-1:0] obs,
                       input logic [PROD_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a start for one edge; afterwards we sit just past the start edge T.
  task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input string tag);
    mif.indata_a_i = a;
    mif.indata_b_i = b;
    mif.start_i    = 1'b1;
    step();
    mif.start_i = 1'b0;
    check({tag, "_busy_T"}, PROD_W'(mif.busy_o), PROD_W'(1));
    check({tag, "_fin_T"}, PROD_W'(mif.finish_o), PROD_W'(0));
  endtask

  // From edge T: busy through T+5, single finish at T+6 with the product.
  task automatic expect_finish(input logic [PROD_W-1:0] exp, input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (mif.busy_o !== 1'b1 || mif.finish_o !== 1'b0) bad = 1'b1;
    end
    check({tag, "_busy_window"}, PROD_W'(bad), PROD_W'(0));
    step();
    check({tag, "_finish"}, PROD_W'(mif.finish_o), PROD_W'(1));
    check({tag, "_busy_off"}, PROD_W'(mif.busy_o), PROD_W'(0));
    check({tag, "_product"}, mif.outdata_r_o, exp);
  endtask

  task automatic watch_no_finish(input int cycles, input string tag);
    seen_finish = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (mif.finish_o === 1'b1) seen_finish = 1'b1;
    end
    check({tag, "_no_finish"}, PROD_W'(seen_finish), PROD_W'(0));
  endtask

  initial begin
    n_checks       = 0;
    n_errs         = 0;
    mif.start_i    = 1'b0;
    mif.indata_a_i = '0;
    mif.indata_b_i = '0;
    rst            = 1'b1;
    step();
    step();
    check("rst_busy", PROD_W'(mif.busy_o), PROD_W'(0));
    check("rst_finish", PROD_W'(mif.finish_o), PROD_W'(0));
    check("rst_out", mif.outdata_r_o, PROD_W'(0));
    check("rst_state", PROD_W'(mif.dbg_state), PROD_W'(IDLE));
    rst = 1'b0;
    step();

    // basic timing
    start_op(64'd3, 64'd5, "basic");
    expect_finish(128'h0F, "basic");
    step();
    check("basic_pulse_end", PROD_W'(mif.finish_o), PROD_W'(0));
    check("basic_hold", mif.outdata_r_o, 128'h0F);

    // arithmetic corners
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "max");
    expect_finish(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "max");
    step();
    start_op(64'h1_0000_0000, 64'h1_0000_0000, "limb");
    expect_finish(128'h1_0000_0000_0000_0000, "limb");
    step();
    start_op(64'h0, 64'hDEAD_BEEF, "zero");
    expect_finish(128'h0, "zero");
    step();
    start_op(64'h1_0000_0001, 64'h1_0000_0001, "cross");
    expect_finish(128'h1_0000_0002_0000_0001, "cross");
    step();
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, "carry");
    expect_finish(128'h1_FFFF_FFFF_FFFF_FFFE, "carry");
    step();

    // second start while busy is dropped; operand changes after T are ignored
    start_op(64'd7, 64'd6, "busy");
    step();
    mif.indata_a_i = 64'd100;
    mif.indata_b_i = 64'd100;
    mif.start_i    = 1'b1;
    step();
    mif.start_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("busy_no_early_fin", PROD_W'(mif.finish_o), PROD_W'(0));
    step();
    check("busy_finish", PROD_W'(mif.finish_o), PROD_W'(1));
    check("busy_product", mif.outdata_r_o, 128'd42);
    watch_no_finish(8, "busy_after");

    // back-to-back: start held during the finish cycle
    start_op(64'd3, 64'd5, "b2b1");
    expect_finish(128'h0F, "b2b1");
    start_op(64'd9, 64'd11, "b2b2");
    check("b2b_hold_prev", mif.outdata_r_o, 128'h0F);
    expect_finish(128'd99, "b2b2");
    step();

    // reset mid-operation
    start_op(64'd5, 64'd5, "abort");
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", PROD_W'(mif.busy_o), PROD_W'(0));
    check("abort_out", mif.outdata_r_o, PROD_W'(0));
    check("abort_state", PROD_W'(mif.dbg_state), PROD_W'(IDLE));
    watch_no_finish(10, "abort");

    // recovery after the abort
    start_op(64'd2, 64'd3, "recover");
    expect_finish(128'd6, "recover");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
